// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED bank sequencer: prescaled rotate/bounce/blink patterns,
// reconfigured through a valid/ready handshake and frozen by a pause level.
module led_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIV   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [1:0]       cfg_speed,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_ROTL   = 2'd0,
    M_ROTR   = 2'd1,
    M_BOUNCE = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  localparam logic [31:0]      DIV_W   = 32'(DIV);
  localparam logic [WIDTH-1:0] PAT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_MSB = PAT_ONE << (WIDTH - 1);
  localparam logic             DIR_LEFT  = 1'b0;
  localparam logic             DIR_RIGHT = 1'b1;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [1:0]       speed_q, speed_d;
  logic             dir_q, dir_d;
  logic [31:0]      count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;

  logic [31:0]      limit;
  logic             tick;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] stepped_led;
  logic             stepped_dir;
  logic [WIDTH-1:0] init_led;

  assign cfg_ready = !rst && (state_q != ST_LOAD);
  assign accept    = cfg_valid && cfg_ready;
  assign limit     = (DIV_W << speed_q) - 32'd1;
  assign tick      = (count_q == limit);
  assign led       = led_q;
  assign step      = step_q;

  always_comb begin
    init_led = PAT_ONE;
    case (mode_q)
      M_ROTL:   init_led = PAT_ONE;
      M_ROTR:   init_led = PAT_MSB;
      M_BOUNCE: init_led = PAT_ONE;
      M_BLINK:  init_led = '1;
      default:  init_led = PAT_ONE;
    endcase
  end

  // Bounce turns around at either end in the same step, so endpoints never repeat.
  always_comb begin
    stepped_led = led_q;
    stepped_dir = dir_q;
    case (mode_q)
      M_ROTL: stepped_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      M_ROTR: stepped_led = {led_q[0], led_q[WIDTH-1:1]};
      M_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          if (led_q[WIDTH-1]) begin
            stepped_dir = DIR_RIGHT;
            stepped_led = led_q >> 1;
          end else begin
            stepped_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            stepped_dir = DIR_LEFT;
            stepped_led = led_q << 1;
          end else begin
            stepped_led = led_q >> 1;
          end
        end
      end
      M_BLINK: stepped_led = ~led_q;
      default: stepped_led = led_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    count_d = count_q;
    led_d   = led_q;
    step_d  = 1'b0;
    advance = 1'b0;

    if (accept) begin
      mode_d  = mode_t'(cfg_mode);
      speed_d = cfg_speed;
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) state_d = ST_PAUSED;
          else       advance = 1'b1;
        end
        // The release cycle already counts, so a pause costs exactly its high cycles.
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
            advance = 1'b1;
          end
        end
        ST_LOAD: begin
          led_d   = init_led;
          count_d = 32'd0;
          dir_d   = DIR_LEFT;
          state_d = pause ? ST_PAUSED : ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    if (advance) begin
      if (tick) begin
        count_d = 32'd0;
        led_d   = stepped_led;
        dir_d   = stepped_dir;
        step_d  = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      mode_q  <= M_ROTL;
      speed_q <= 2'd0;
      dir_q   <= DIR_LEFT;
      count_q <= 32'd0;
      led_q   <= PAT_ONE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl (DIV=4, WIDTH=16).
module tb_led_seq_ctrl;
  localparam int W   = 16;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_mode;
  logic [1:0]   cfg_speed;
  logic         pause;
  logic [W-1:0] led;
  logic         step;

  led_seq_ctrl #(.WIDTH(W), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_speed (cfg_speed),
    .pause     (pause),
    .led       (led),
    .step      (step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           t;
    logic [W-1:0] led;
    logic         step;
  } ev_t;

  typedef struct {
    int           t;
    int           kind;
    logic [W-1:0] val;
  } pr_t;

  ev_t ev_q[$];
  pr_t pr_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  bit  done   = 1'b0;

  // Monitor: every led change or step pulse must match the next expected event.
  always @(negedge clk) begin : monitor
    ev_t          e;
    pr_t          p;
    logic [W-1:0] act;
    logic [W-1:0] prev_led;
    if (mon_en) begin
      while (ev_q.size() > 0 && ev_q[0].t < cyc) begin
        e = ev_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: cyc=%0d led=%h not seen, required at cyc=%0d led=%h step=%b",
                 cyc, led, e.t, e.led, e.step);
      end
      if (led !== prev_led || step !== 1'b0) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc=%0d led=%h step=%b, required no change", cyc, led, step);
        end else begin
          e = ev_q.pop_front();
          if (led !== e.led || step !== e.step || cyc != e.t) begin
            errors++;
            $display("FAIL event: got cyc=%0d led=%h step=%b, required cyc=%0d led=%h step=%b",
                     cyc, led, step, e.t, e.led, e.step);
          end
        end
      end
    end
    prev_led = led;
    while (pr_q.size() > 0 && pr_q[0].t <= cyc) begin
      p = pr_q.pop_front();
      checks++;
      case (p.kind)
        0:       act = {{(W-1){1'b0}}, cfg_ready};
        1:       act = led;
        default: act = {{(W-1){1'b0}}, step};
      endcase
      if (p.t != cyc || act !== p.val) begin
        errors++;
        $display("FAIL probe%0d: cyc=%0d got %h, required %h at cyc=%0d", p.kind, cyc, act, p.val, p.t);
      end
    end
    if (done) begin
      checks++;
      if (ev_q.size() != 0 || pr_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d events %0d probes pending, required 0", ev_q.size(), pr_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (cyc > 3000) begin
      errors++;
      checks++;
      $display("FAIL timeout: cyc=%0d, required finish before 3000", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) nxt(1);
  endtask

  task automatic push_ev(input int t, input logic [W-1:0] v, input logic s);
    ev_q.push_back('{t, v, s});
  endtask

  task automatic probe(input int kind, input logic [W-1:0] v);
    pr_q.push_back('{cyc, kind, v});
  endtask

  // Offers a configuration; returns the LOAD cycle (the accept edge).
  task automatic do_accept(input logic [1:0] m, input logic [1:0] s, output int a);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_speed = s;
    probe(0, 16'h0001);
    nxt(1);
    cfg_valid = 1'b0;
    a = cyc;
    probe(0, 16'h0000);
  endtask

  function automatic logic [W-1:0] bounce_pat(input int k);
    logic [W-1:0] one;
    one = 16'h0001;
    if (k <= 15)      return one << k;
    else if (k <= 30) return one << (30 - k);
    else              return one << (k - 30);
  endfunction

  initial begin
    int c0, a, l, c1;
    logic [W-1:0] one;
    one       = 16'h0001;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_speed = 2'd0;
    pause     = 1'b0;

    nxt(3);
    probe(0, 16'h0000);
    probe(1, 16'h0001);
    probe(2, 16'h0000);
    nxt(1);
    rst = 1'b0;
    c0  = cyc;
    probe(0, 16'h0001);
    mon_en = 1'b1;

    for (int k = 1; k <= 17; k++) push_ev(c0 + 4 * k, one << (k % 16), 1'b1);
    wait_until(c0 + 69);

    do_accept(2'd2, 2'd1, a);
    push_ev(a + 1, 16'h0001, 1'b0);
    nxt(1);
    probe(0, 16'h0001);
    for (int k = 1; k <= 31; k++) push_ev(a + 1 + 8 * k, bounce_pat(k), 1'b1);
    wait_until(a + 1 + 248 + 1);

    do_accept(2'd1, 2'd0, a);
    push_ev(a + 1, 16'h8000, 1'b0);
    nxt(1);
    probe(0, 16'h0001);
    for (int k = 1; k <= 16; k++) push_ev(a + 1 + 4 * k, (k == 16) ? 16'h8000 : (16'h8000 >> k), 1'b1);
    wait_until(a + 1 + 64 + 1);

    do_accept(2'd3, 2'd0, a);
    push_ev(a + 1, 16'hFFFF, 1'b0);
    nxt(1);
    probe(0, 16'h0001);
    push_ev(a + 5, 16'h0000, 1'b1);
    push_ev(a + 9, 16'hFFFF, 1'b1);
    push_ev(a + 13, 16'h0000, 1'b1);
    l = a + 13;

    push_ev(l + 14, 16'hFFFF, 1'b1);
    wait_until(l + 2);
    pause = 1'b1;
    nxt(5);
    probe(1, 16'h0000);
    probe(2, 16'h0000);
    wait_until(l + 12);
    pause = 1'b0;

    push_ev(l + 19, 16'h0000, 1'b1);
    wait_until(l + 17);
    pause = 1'b1;
    nxt(1);
    pause = 1'b0;
    probe(1, 16'hFFFF);
    probe(2, 16'h0000);

    wait_until(l + 22);
    do_accept(2'd0, 2'd0, a);
    push_ev(a + 1, 16'h0001, 1'b0);
    nxt(1);
    probe(0, 16'h0001);
    push_ev(a + 5, 16'h0002, 1'b1);

    wait_until(a + 6);
    pause = 1'b1;
    nxt(2);
    do_accept(2'd2, 2'd0, a);
    push_ev(a + 1, 16'h0001, 1'b0);
    nxt(1);
    probe(0, 16'h0001);
    push_ev(a + 14, 16'h0002, 1'b1);
    wait_until(a + 6);
    probe(1, 16'h0001);
    wait_until(a + 10);
    pause = 1'b0;

    wait_until(a + 14);
    do_accept(2'd1, 2'd2, a);
    rst = 1'b1;
    push_ev(a + 1, 16'h0001, 1'b0);
    nxt(1);
    probe(0, 16'h0000);
    probe(2, 16'h0000);
    nxt(1);
    rst = 1'b0;
    c1  = cyc;
    probe(0, 16'h0001);
    for (int k = 1; k <= 3; k++) push_ev(c1 + 4 * k, one << k, 1'b1);
    wait_until(c1 + 14);
    done = 1'b1;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Controller that sequences the 16-bit board LED bank. It owns the prescaler and the pattern register, and steps the LEDs through one of four patterns (rotate-left, rotate-right, bounce, blink) at a configurable rate. Software and the switch-decoding logic reconfigure it through a valid/ready handshake, and a pause input freezes it. It sits between the top-level configuration/switch logic and the physical LED pins.

## Interface
- WIDTH, 16: number of LEDs; must be ≥ 2.
- DIV, 5000000: base step period in clk cycles; must be ≥ 1, and DIV<<3 must fit in 32 bits.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  controller can accept a configuration this cycle
- cfg_mode  in  2  0=ROTL, 1=ROTR, 2=BOUNCE, 3=BLINK; sampled on accept
- cfg_speed  in  2  step period = DIV<<cfg_speed cycles; sampled on accept
- pause  in  1  level; freezes stepping while high
- led  out  WIDTH  LED pattern (registered)
- step  out  1  one-cycle pulse in the first cycle a new led value is visible

## Operation
- FSM states:
  - RUN: prescaler counts; a tick steps the pattern.
  - PAUSED: counter and led hold.
  - LOAD: one cycle; applies the accepted configuration.
- Accept: cfg_valid & cfg_ready at a clock edge.
  - cfg_mode and cfg_speed are latched into the mode/speed registers.
  - The next state is LOAD.
- LOAD actions:
  - led <= initial pattern of the new mode.
  - count <= 0; bounce direction <= left.
  - Next state is PAUSED if pause=1, else RUN.
- cfg_ready = 0 while rst=1 or in LOAD; otherwise 1. Acceptance is possible in RUN and in PAUSED.
- Prescaler:
  - limit = (DIV<<speed) - 1, 32-bit.
  - In RUN, tick = (count == limit). On tick, count <= 0; otherwise count <= count + 1.
- Steps, applied on tick:
  - ROTL: initial pattern 1. Step: led <= {led[W-2:0], led[W-1]}.
  - ROTR: initial pattern 1<<(W-1). Step: led <= {led[0], led[W-1:1]}.
  - BOUNCE: initial pattern 1, direction left.
    - Left: if led[W-1]=1, flip to right and led <= led>>1; else led <= led<<1.
    - Right: if led[0]=1, flip to left and led <= led<<1; else led <= led>>1.
    - Sequence: 1, 2, …, 2^(W-1), 2^(W-2), …, 1, 2, … with period 2W-2 steps and no repeated endpoint.
  - BLINK: initial pattern all ones. Step: led <= ~led.
- step <= 1 for exactly one cycle per applied step. It is never asserted for LOAD or reset loads.
- Pause:
  - RUN with pause=1: go to PAUSED. No count increment and no step in that cycle, even if count == limit.
  - PAUSED with pause=0 and no accept: go to RUN; the counter resumes from the held value.
- Priority within a cycle: rst > accept > pause > tick. An accept on a tick cycle discards that step.
- Reset values: led=1, mode=ROTL, speed=0, direction=left, count=0, step=0, state=RUN, cfg_ready=0 (becomes 1 in the first cycle after rst deasserts).
- Reset mid-operation, including in LOAD or PAUSED, gives the reset values on the next edge. No pending configuration survives.

## Timing
- Uninterrupted RUN: led changes every DIV<<speed cycles exactly.
- After reset or LOAD (count=0), the first change is visible DIV<<speed cycles after the cycle in which count=0.
- Accept at edge N: the state is LOAD during cycle N+1, and the initial pattern is visible from cycle N+2.
- cfg_ready returns to 1 in cycle N+2.
- step coincides with the first cycle a new led value is visible.
- Each paused cycle lengthens the current step period by exactly one cycle.

## Test plan
Bench parameters: DIV=4, WIDTH=16.
- Reset, then idle, speed 0: led 0x0001, 0x0002, 0x0004, … changing every 4 cycles, with a step pulse at each change. After 16 steps led = 0x0001 again.
- Accept mode=BOUNCE, speed=1:
  - cfg_ready is low for one cycle.
  - led=0x0001 two cycles after the accept edge, then changes every 8 cycles.
  - Sequence 0x0001 … 0x8000, 0x4000 … 0x0001, 0x0002; 0x8000 and 0x0001 are never repeated back-to-back.
- Accept mode=ROTR, then mode=BLINK:
  - ROTR: 0x8000, 0x4000, …, 0x0001, 0x8000.
  - BLINK: 0xFFFF, 0x0000, 0xFFFF at a 4-cycle period.
- Pause:
  - Hold pause high for 10 cycles when count=2: led and step are frozen.
  - After release, the next change occurs exactly 10 cycles later than it would have without the pause.
  - Pause asserted in the count==limit cycle: no step that cycle.
- Simultaneous events:
  - cfg_valid on a tick cycle: the step is discarded and the new initial pattern loads.
  - Accept while paused: LOAD, then PAUSED, with led holding the initial pattern.
- Reset mid-operation:
  - rst asserted during LOAD gives led=0x0001, ROTL, speed 0, step=0.
  - cfg_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
